// File: rtl/segment_scan_driver.sv
// Scans a 16-bit snapshot as four hex digits onto one common-anode 7-segment bank.
// A new snapshot is held pending and committed only at a scan-frame boundary, so the digits never tear.
module segment_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] first_segment,
  input  logic [3:0] second_segment,
  input  logic [7:0] read_address,
  input  logic       blank_zero,
  output logic [3:0] anode,
  output logic [6:0] cathode,
  output logic       dp,
  output logic       pending
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescale_q, prescale_d;
  logic [1:0]    index_q, index_d;
  logic [15:0]   display_q, display_d;
  logic [15:0]   buffer_q, buffer_d;
  logic          pending_q, pending_d;
  logic [3:0]    anode_q, anode_d;
  logic [6:0]    cathode_q, cathode_d;
  logic          dp_q, dp_d;

  logic          tick;
  logic          frame_start;
  logic [1:0]    slot;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] seg;
    seg = 7'h7F;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  always_comb begin
    tick        = (prescale_q == LAST);
    prescale_d  = tick ? '0 : prescale_q + 1'b1;
    index_d     = tick ? index_q + 2'd1 : index_q;
    frame_start = tick && (index_q == 2'd3);
    // The output stage registers the slot that becomes current after this tick.
    slot        = index_q + 2'd1;
    nibble      = display_q[{slot, 2'b00} +: 4];

    display_d = display_q;
    buffer_d  = buffer_q;
    pending_d = pending_q;
    if (frame_start && pending_q) begin
      display_d = buffer_q;
      pending_d = 1'b0;
    end
    // A load on the boundary still commits the old buffer and keeps the new sample pending.
    if (load) begin
      buffer_d  = {read_address, first_segment, second_segment};
      pending_d = 1'b1;
    end

    anode_d   = anode_q;
    cathode_d = cathode_q;
    dp_d      = dp_q;
    if (tick) begin
      anode_d   = ~(4'b0001 << slot);
      cathode_d = (slot == 2'd3 && blank_zero && nibble == 4'h0) ? 7'h7F : hex7seg(nibble);
      dp_d      = (slot != 2'd2);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      prescale_q <= '0;
      index_q    <= 2'd0;
      display_q  <= 16'h0000;
      buffer_q   <= 16'h0000;
      pending_q  <= 1'b0;
      anode_q    <= 4'hF;
      cathode_q  <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      prescale_q <= prescale_d;
      index_q    <= index_d;
      display_q  <= display_d;
      buffer_q   <= buffer_d;
      pending_q  <= pending_d;
      anode_q    <= anode_d;
      cathode_q  <= cathode_d;
      dp_q       <= dp_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;
  assign dp      = dp_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_segment_scan_driver.sv
// Bench for segment_scan_driver: an edge-counting reference pushes expected digit outputs per tick,
// a negedge monitor pops and compares; directed sequences check frames, collisions, blanking and reset.
module tb_segment_scan_driver;
  localparam int RD = 4;
  localparam int FRAME = 4 * RD;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] ca;
    logic       dp;
  } exp_t;

  localparam exp_t RST_EXP = {4'hF, 7'h7F, 1'b1};
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       blank_zero = 1'b0;
  logic [3:0] first_segment = 4'h0;
  logic [3:0] second_segment = 4'h0;
  logic [7:0] read_address = 8'h00;
  logic [3:0] anode;
  logic [6:0] cathode;
  logic       dp;
  logic       pending;

  int total = 0;
  int bad = 0;

  int unsigned edge_n = 0;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_buf = 16'h0;
  logic        m_pend = 1'b0;
  exp_t        cur = RST_EXP;
  exp_t        q[$];

  segment_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clock          (clock),
    .clear          (clear),
    .load           (load),
    .first_segment  (first_segment),
    .second_segment (second_segment),
    .read_address   (read_address),
    .blank_zero     (blank_zero),
    .anode          (anode),
    .cathode        (cathode),
    .dp             (dp),
    .pending        (pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: edge n after release is a tick when n%RD==0; the slot it drives is (n/RD)%4.
  always @(posedge clock or negedge clear) begin : model
    int unsigned n;
    int slot;
    logic [3:0] nib;
    exp_t e;
    if (!clear) begin
      edge_n <= 0;
      m_disp <= 16'h0;
      m_buf  <= 16'h0;
      m_pend <= 1'b0;
    end else begin
      n = edge_n + 1;
      edge_n <= n;
      if (n % RD == 0) begin
        slot = (n / RD) % 4;
        nib  = m_disp[slot*4 +: 4];
        e.an = ~(4'b0001 << slot);
        e.ca = (slot == 3 && blank_zero && nib == 4'h0) ? 7'h7F : SEG[nib];
        e.dp = (slot != 2);
        q.push_back(e);
      end
      if (n % FRAME == 0 && m_pend) m_disp <= m_buf;
      if (load) begin
        m_buf  <= {read_address, first_segment, second_segment};
        m_pend <= 1'b1;
      end else if (n % FRAME == 0) begin
        m_pend <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin : mon
    exp_t e;
    if (!clear) begin
      q.delete();
      e = RST_EXP;
    end else begin
      e = cur;
      if (q.size() != 0) e = q.pop_front();
    end
    cur <= e;
    chk("mon_anode", anode, e.an);
    chk("mon_cathode", cathode, e.ca);
    chk("mon_dp", dp, e.dp);
    chk("mon_pending", pending, m_pend);
    if (anode != 4'hF) chk("mon_onehot", $countones(~anode), 1);
  end

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while ((edge_n % FRAME) != ph && k < 100);
    if (k >= 100) chk("phase_timeout", 0, 1);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [3:0] f, input logic [3:0] s);
    read_address   = a;
    first_segment  = f;
    second_segment = s;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
  endtask

  task automatic wait_pend_low();
    int k;
    k = 0;
    while (pending !== 1'b0 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("pend_clear_timeout", pending, 0);
  endtask

  // Records one full frame: slots 1,2,3 then 0 (the frame_start slot).
  task automatic capture(output logic [27:0] cat, output logic [15:0] an, output logic [3:0] dps);
    cat = '0;
    an  = '0;
    dps = '0;
    wait_phase(4);
    for (int i = 0; i < 4; i++) begin
      int s;
      s = (i + 1) % 4;
      cat[s*7 +: 7] = cathode;
      an[s*4 +: 4]  = anode;
      dps[s]        = dp;
      if (i < 3) repeat (RD) @(negedge clock);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [27:0] cat;
    logic [15:0] an;
    logic [3:0]  dps;
    int k;

    repeat (10) begin
      @(negedge clock);
      chk("rst_anode", anode, 4'hF);
      chk("rst_cathode", cathode, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_pending", pending, 1'b0);
    end
    clear = 1'b1;
    k = 0;
    while (k < 20) begin
      @(posedge clock);
      #1;
      k++;
      if (anode != 4'hF) break;
    end
    chk("first_lit_cycles", k, 4);
    chk("first_lit_anode", anode, 4'b1101);

    wait_phase(5);
    do_load(8'hA5, 4'h3, 4'h9);
    chk("ld_pending_set", pending, 1'b1);
    wait_pend_low();
    capture(cat, an, dps);
    chk("ld_d3", cat[21 +: 7], 7'h08);
    chk("ld_d2", cat[14 +: 7], 7'h12);
    chk("ld_d1", cat[7 +: 7], 7'h30);
    chk("ld_d0", cat[0 +: 7], 7'h10);
    chk("ld_dp", dps, 4'b1011);
    chk("ld_dp_anode", an[8 +: 4], 4'b1011);

    wait_phase(5);
    do_load(8'h12, 4'h3, 4'h4);
    wait_phase(15);
    do_load(8'h56, 4'h7, 4'h8);
    chk("col_pending_held", pending, 1'b1);
    capture(cat, an, dps);
    chk("col_frame_n", cat, {7'h79, 7'h24, 7'h30, 7'h19});
    chk("col_pending_cleared", pending, 1'b0);
    capture(cat, an, dps);
    chk("col_frame_n1", cat, {7'h12, 7'h02, 7'h78, 7'h00});
    chk("col_pending_after", pending, 1'b0);

    blank_zero = 1'b1;
    wait_phase(5);
    do_load(8'h07, 4'h0, 4'h0);
    wait_pend_low();
    capture(cat, an, dps);
    chk("blank_d3", cat[21 +: 7], 7'h7F);
    chk("blank_d3_anode", an[12 +: 4], 4'b0111);
    chk("blank_d2", cat[14 +: 7], 7'h78);
    blank_zero = 1'b0;
    capture(cat, an, dps);
    chk("noblank_d3", cat[21 +: 7], 7'h40);

    for (int v = 0; v < 16; v++) begin
      wait_phase(5);
      do_load(8'h00, 4'h0, 4'(v));
      wait_pend_low();
      capture(cat, an, dps);
      chk("sweep_d0", cat[0 +: 7], SEG[v]);
      chk("sweep_d0_anode", an[0 +: 4], 4'b1110);
    end

    wait_phase(5);
    do_load(8'hFF, 4'hF, 4'hF);
    wait_phase(9);
    chk("midrst_pending_pre", pending, 1'b1);
    #2 clear = 1'b0;
    #1;
    chk("midrst_anode", anode, 4'hF);
    chk("midrst_cathode", cathode, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    chk("midrst_pending", pending, 1'b0);
    repeat (2) @(negedge clock);
    clear = 1'b1;
    capture(cat, an, dps);
    chk("midrst_display", cat, {4{7'h40}});
    chk("midrst_pending_post", pending, 1'b0);

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
